// File: rtl/traversal_pkg.sv
// rtl/traversal_pkg.sv - shared FSM state and bit-order constants for traversal_collect
package traversal_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BIT = 2'd1,
    WAIT_FIN = 2'd2,
    HOLD     = 2'd3
  } state_e;

  localparam int DIR_MSB_FIRST = 0;
  localparam int DIR_LSB_FIRST = 1;

endpackage

// File: rtl/toggle_sync.sv
// rtl/toggle_sync.sv - multi-flop synchroniser turning a two-phase level into a one-cycle event pulse
module toggle_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic event_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  hist_q, hist_d;

  // Shift the raw level through the chain; history holds the previous settled level
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], async_in};
    hist_d = sync_q[SyncStages-1];
  end

  // Chain and history registers, cleared so a low input after reset is not an event
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // Either polarity of transition on the settled level counts as one event
  assign event_o = sync_q[SyncStages-1] ^ hist_q;

endmodule

// File: rtl/traversal_collect.sv
// rtl/traversal_collect.sv - clocked collector of traversal serial bits into a valid/ready word; optional watchdog via TRAVERSAL_COLLECT_TIMEOUT_EN
module traversal_collect
  import traversal_pkg::*;
#(
  parameter int Width         = 32,
  parameter int Direction     = 0,
  parameter int SyncStages    = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [Width-1:0] word_data,
  output logic             err,
  output logic             tr_req,
  output logic             tr_reqDo,
  input  logic             tr_doFin,
  input  logic             tr_fin,
  input  logic             tr_data
);

  localparam int CW = $clog2(Width) + 1;

  // Reject configurations the shift and synchroniser logic cannot support
  if (Width < 2) begin : g_bad_width
    $error("traversal_collect: Width must be >= 2");
  end
  if (SyncStages < 2) begin : g_bad_sync
    $error("traversal_collect: SyncStages must be >= 2");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("traversal_collect: TimeoutCycles must be >= 1");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [Width-1:0] word_q, word_d, word_shift;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             req_q, req_d;
  logic             reqdo_q, reqdo_d;
  logic             dofin_ev, fin_ev;
  logic             tmo_hit;
  logic             fail;

  toggle_sync #(.SyncStages(SyncStages)) u_sync_dofin (
    .clk     (clk),
    .rst     (rst),
    .async_in(tr_doFin),
    .event_o (dofin_ev)
  );

  toggle_sync #(.SyncStages(SyncStages)) u_sync_fin (
    .clk     (clk),
    .rst     (rst),
    .async_in(tr_fin),
    .event_o (fin_ev)
  );

  // Next-state logic: request toggling, bit collection and protocol checking
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    req_d   = req_q;
    reqdo_d = reqdo_q;
    fail    = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    if (Direction == DIR_MSB_FIRST) begin
      word_shift = {word_q[Width-2:0], tr_data};
    end else begin
      word_shift = {tr_data, word_q[Width-1:1]};
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          req_d   = ~req_q;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = WAIT_BIT;
        end
      end
      WAIT_BIT: begin
        if (fin_ev) begin
          fail = 1'b1;
        end else if (dofin_ev) begin
          word_d  = word_shift;
          cnt_d   = cnt_inc;
          reqdo_d = ~reqdo_q;
          if (cnt_inc == CW'(Width)) begin
            state_d = WAIT_FIN;
          end
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      WAIT_FIN: begin
        if (dofin_ev) begin
          fail = 1'b1;
        end else if (fin_ev) begin
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      HOLD: begin
        if (word_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any violation abandons the word without touching the request lines
    if (fail) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

`ifdef TRAVERSAL_COLLECT_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles) + 1;

  logic [TW-1:0] tmo_q, tmo_d;

  // Watchdog counts idle waiting cycles; any event or state change restarts it
  always_comb begin
    tmo_d = '0;
    if ((state_q == WAIT_BIT || state_q == WAIT_FIN) && (state_d == state_q) &&
        !(dofin_ev || fin_ev)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (tmo_q == TW'(TimeoutCycles - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      reqdo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      req_q   <= req_d;
      reqdo_q <= reqdo_d;
    end
  end

  assign busy       = busy_q;
  assign word_valid = valid_q;
  assign word_data  = word_q;
  assign err        = err_q;
  assign tr_req     = req_q;
  assign tr_reqDo   = reqdo_q;

endmodule

// File: tb/tb_traversal_collect.sv
// tb/tb_traversal_collect.sv - randomized self-checking bench for traversal_collect (MSB-first and LSB-first instances)
module tb_traversal_collect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [2];
  logic       rdy   [2];
  logic       dofin [2];
  logic       fin   [2];
  logic       tdata [2];
  logic       busy  [2];
  logic       valid [2];
  logic       err   [2];
  logic       req   [2];
  logic       reqdo [2];
  logic [7:0] wdata [2];

  int checks = 0;
  int errors = 0;

  int   req_cnt   [2] = '{0, 0};
  int   reqdo_cnt [2] = '{0, 0};
  int   err_cnt   [2] = '{0, 0};
  int   valid_cnt [2] = '{0, 0};
  logic req_p     [2] = '{1'b0, 1'b0};
  logic reqdo_p   [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  traversal_collect #(.Width(8), .Direction(0), .SyncStages(2), .TimeoutCycles(16)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .word_valid(valid[0]),
    .word_ready(rdy[0]), .word_data(wdata[0]), .err(err[0]), .tr_req(req[0]),
    .tr_reqDo(reqdo[0]), .tr_doFin(dofin[0]), .tr_fin(fin[0]), .tr_data(tdata[0])
  );

  traversal_collect #(.Width(8), .Direction(1), .SyncStages(2), .TimeoutCycles(16)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .word_valid(valid[1]),
    .word_ready(rdy[1]), .word_data(wdata[1]), .err(err[1]), .tr_req(req[1]),
    .tr_reqDo(reqdo[1]), .tr_doFin(dofin[1]), .tr_fin(fin[1]), .tr_data(tdata[1])
  );

  // Handshake and pulse accounting, observed mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (req[i] !== req_p[i]) req_cnt[i]++;
      if (reqdo[i] !== reqdo_p[i]) reqdo_cnt[i]++;
      if (err[i] === 1'b1) err_cnt[i]++;
      if (valid[i] === 1'b1) valid_cnt[i]++;
      req_p[i]   = req[i];
      reqdo_p[i] = reqdo[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  // Traversal model: present each bit, toggle doFin, wait for the per-bit advance
  task automatic feed_bits(input int i, input logic [7:0] din, input int n);
    for (int k = 0; k < n; k++) begin
      logic p;
      int   w;
      p        = reqdo[i];
      tdata[i] = (i == 0) ? din[7-k] : din[k];
      repeat ($urandom_range(0, 2)) tick();
      dofin[i] = ~dofin[i];
      w = 0;
      while (reqdo[i] === p && w < 40) begin
        tick();
        w++;
      end
      check("reqdo_ack", 32'(reqdo[i] !== p), 1);
    end
  endtask

  task automatic wait_err(input int i, output int n);
    n = 0;
    while (err[i] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dofin[i] = 1'b0;
      fin[i]   = 1'b0;
      start[i] = 1'b0;
      rdy[i]   = 1'b0;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input int i);
    check("rst_busy", 32'(busy[i]), 0);
    check("rst_valid", 32'(valid[i]), 0);
    check("rst_data", 32'(wdata[i]), 0);
    check("rst_err", 32'(err[i]), 0);
    check("rst_req", 32'(req[i]), 0);
    check("rst_reqdo", 32'(reqdo[i]), 0);
  endtask

  // One clean word: expected result is the loaded dataIn, one req toggle, Width reqDo toggles
  task automatic normal_word(input int i, input logic [7:0] din, input int hold);
    int r0, d0, e0, n;
    bit stable;
    r0 = req_cnt[i];
    d0 = reqdo_cnt[i];
    e0 = err_cnt[i];
    pulse_start(i);
    check("busy_on", 32'(busy[i]), 1);
    pulse_start(i);
    feed_bits(i, din, 8);
    repeat ($urandom_range(0, 3)) tick();
    fin[i] = ~fin[i];
    n = 0;
    while (valid[i] !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("valid_latency", n, 3);
    check("word", 32'(wdata[i]), 32'(din));
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (wdata[i] !== din || busy[i] !== 1'b1 || valid[i] !== 1'b1) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 1);
    rdy[i] = 1'b1;
    tick();
    rdy[i] = 1'b0;
    check("handoff_valid", 32'(valid[i]), 0);
    check("handoff_busy", 32'(busy[i]), 0);
    tick();
    check("req_toggles", req_cnt[i] - r0, 1);
    check("reqdo_toggles", reqdo_cnt[i] - d0, 8);
    check("no_err", err_cnt[i] - e0, 0);
  endtask

  initial begin
    int e0, v0, n;
    bit ok;
    logic [7:0] w;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; rdy[i] = 1'b0; dofin[i] = 1'b0; fin[i] = 1'b0; tdata[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals(0);
    check_reset_vals(1);
    rst = 1'b0;
    tick();

    normal_word(0, 8'hA5, 0);
    normal_word(1, 8'h3C, 0);
    normal_word(1, 8'h3C, 20);

    for (int r = 0; r < 10; r++) begin
      w = 8'($urandom);
      normal_word(int'($urandom_range(0, 1)), w, int'($urandom_range(0, 5)));
    end

    // fin arrives after only five bits
    e0 = err_cnt[0];
    v0 = valid_cnt[0];
    pulse_start(0);
    feed_bits(0, 8'hFF, 5);
    fin[0] = ~fin[0];
    wait_err(0, n);
    check("early_fin_err", 32'(err[0]), 1);
    check("early_fin_busy", 32'(busy[0]), 0);
    tick();
    tick();
    check("early_fin_pulses", err_cnt[0] - e0, 1);
    check("early_fin_novalid", valid_cnt[0] - v0, 0);
    normal_word(0, 8'hFF, 0);

    // doFin and fin together while waiting for fin
    e0 = err_cnt[0];
    v0 = valid_cnt[0];
    pulse_start(0);
    w = 8'($urandom);
    feed_bits(0, w, 8);
    dofin[0] = ~dofin[0];
    fin[0]   = ~fin[0];
    wait_err(0, n);
    check("simul_err", 32'(err[0]), 1);
    check("simul_busy", 32'(busy[0]), 0);
    tick();
    tick();
    check("simul_pulses", err_cnt[0] - e0, 1);
    check("simul_novalid", valid_cnt[0] - v0, 0);
    normal_word(0, 8'h5A, 0);

    // reset after the third bit
    pulse_start(0);
    feed_bits(0, 8'hC3, 3);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dofin[i] = 1'b0;
      fin[i]   = 1'b0;
    end
    tick();
    check_reset_vals(0);
    tick();
    rst = 1'b0;
    tick();
    normal_word(0, 8'h81, 0);

    // upstream stalls after two bits
    e0 = err_cnt[0];
    pulse_start(0);
    w = 8'($urandom);
    feed_bits(0, w, 2);
`ifdef TRAVERSAL_COLLECT_TIMEOUT_EN
    wait_err(0, n);
    check("timeout_cycle", n, 16);
    check("timeout_busy", 32'(busy[0]), 0);
    tick();
    check("timeout_pulses", err_cnt[0] - e0, 1);
`else
    ok = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (busy[0] !== 1'b1 || err[0] !== 1'b0) ok = 1'b0;
    end
    check("stall_busy_held", 32'(ok), 1);
    check("stall_no_err", err_cnt[0] - e0, 0);
`endif
    reset_all();
    normal_word(1, 8'h96, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traversal_collect.md
Name: traversal_collect

Overview:
- Clocked downstream consumer of the asynchronous `traversal` stage.
- Drives traversal's two-phase req/reqDo handshakes and synchronises the returned doFin/fin transitions into the clock domain.
- Collects the serial dataOut bit stream into a Width-bit word and presents it on a valid/ready interface to synchronous logic.
- Bridges the self-timed FlowControl fabric to clocked consumers.

Parameters:
- Width, 32: word width; must match the upstream traversal Width; >=2.
- Direction, 0: must match traversal Direction. 0 = MSB first, 1 = LSB first.
- SyncStages, 2: flip-flop synchroniser depth on tr_doFin and tr_fin; >=2.
- TimeoutCycles, 1024: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin one word traversal; ignored unless busy=0.
- busy  out  1  high from the cycle after an accepted start until the word is handed off or aborted.
- word_valid  out  1  word_data holds a complete word.
- word_ready  in  1  consumer accepts the word when word_valid & word_ready.
- word_data  out  Width  assembled word.
- err  out  1  one-cycle pulse on a protocol violation (or timeout).
- tr_req  out  1  two-phase request to traversal; toggles once per word.
- tr_reqDo  out  1  two-phase per-bit advance request.
- tr_doFin  in  1  two-phase bit-ready acknowledge; asynchronous.
- tr_fin  in  1  two-phase traversal-complete acknowledge; asynchronous.
- tr_data  in  1  traversal dataOut; bundled data, stable whenever a doFin transition is seen.

Behaviour:
- Reset values: busy=0, word_valid=0, word_data=0, err=0, tr_req=0, tr_reqDo=0. Synchroniser flops and edge-detect history are cleared to 0.
- Reset mid-operation returns to IDLE immediately and does not toggle any request. The upstream traversal must be reset alongside.
- Event detection: an event is one synchronised transition (either polarity) of tr_doFin or tr_fin. The event is seen SyncStages+1 cycles after the input pin toggles.
- tr_data is sampled in the cycle the doFin event is detected.
- Bit counter: cnt, $clog2(Width)+1 bits.
- Shift-in rule:
  - Direction=0: word_data <= {word_data[Width-2:0], tr_data}.
  - Direction=1: word_data <= {tr_data, word_data[Width-1:1]}.
  - After Width samples, word_data equals the traversal dataIn.
- FSM:
  - IDLE: on start, toggle tr_req, set cnt=0, busy=1, go to WAIT_BIT.
  - WAIT_BIT, on doFin event: shift in tr_data and increment cnt, then toggle tr_reqDo. If the new cnt==Width, go to WAIT_FIN; otherwise stay in WAIT_BIT.
  - WAIT_BIT, on fin event: protocol error. Pulse err, go to IDLE, busy=0, word_valid stays 0.
  - WAIT_FIN, on fin event: word_valid=1, go to HOLD.
  - WAIT_FIN, on doFin event: protocol error, handled as above.
  - HOLD: word_data is frozen. On word_valid & word_ready: word_valid=0, busy=0, go to IDLE.
- Handshake totals: Width doFin events and exactly Width tr_reqDo toggles per word.
- Simultaneous doFin and fin events in the same cycle, in any waiting state: protocol error.
- A start received while busy is dropped and does not raise err.
- word_ready is ignored while word_valid=0. The earliest next start is the cycle after handoff.
- Throughput: at most one bit per SyncStages+2 cycles plus upstream delay.

Optional Feature:
- Macro: TRAVERSAL_COLLECT_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BIT and WAIT_FIN and clears on every event and on every state entry.
  - Reaching TimeoutCycles pulses err and returns to IDLE with busy=0.
  - HOLD never times out.
- Undefined: no counter logic; the FSM waits indefinitely for events.

Decomposition:
- Package traversal_pkg: FSM state enum (IDLE, WAIT_BIT, WAIT_FIN, HOLD) and direction constants DIR_MSB_FIRST=0, DIR_LSB_FIRST=1.
- Sub-module toggle_sync: SyncStages-deep synchroniser plus transition detector. It outputs a one-cycle event pulse and is instantiated twice, for tr_doFin and tr_fin.

Test Plan:
- Width=8, Direction=0, behavioural traversal model loaded with 8'hA5, start pulse → exactly 8 tr_reqDo toggles, 1 tr_req toggle; word_valid rises SyncStages+1 cycles after the fin toggle; word_data=8'hA5.
- Direction=1, dataIn 8'h3C → word_data=8'h3C. Repeat with word_ready held low for 20 cycles → word_data stable, busy=1 throughout.
- Model toggles fin after only 5 bits → single err pulse, busy=0, word_valid never asserted. A following start completes a clean 8'hFF word.
- Model toggles doFin and fin simultaneously in WAIT_FIN → err pulse, FSM back in IDLE.
- rst asserted after the 3rd bit → next cycle all outputs at reset values. Re-run with 8'h81 → correct word.
- Macro TRAVERSAL_COLLECT_TIMEOUT_EN defined, TimeoutCycles=16, model stalls after bit 2 → err at cycle 16 of the stall, busy=0. Macro undefined, same stall → busy remains 1 for 1000 cycles with no err.
